fetch_pc_unit: RTL

- Instruction-fetch front end. Owns the program counter, drives a single-outstanding-request instruction-memory handshake, and fills the IF/ID pipeline register.
- Consumes the ID-stage jump target (j/jal/jr/taken-branch address) as a redirect.
- Produces the pc_plus_4/instruction pair that ID uses to compute the next jump target.
- No branch delay slot: a redirect squashes every younger fetch.

---
 rtl/pipeline_pkg.sv | 34 +++
 rtl/fetch_skid_buf.sv | 47 ++++
 rtl/fetch_pc_unit.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_pkg
// Shared types and constants for the instruction-fetch front end.
//   fetch_state_e    : fetch sequencer states (BOOT, REQ, KILL, FULL)
//   if_id_t          : IF/ID pipeline register contents
//   RESET_PC_DEFAULT : first fetch address after reset
//   NOP_INSTR        : instruction word presented while IF/ID is empty
//   next_seq_pc()    : sequential successor of a fetch address (wraps mod 2^32)
// -----------------------------------------------------------------------------
package pipeline_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT = 2'd0,  // one idle cycle after reset release
    REQ  = 2'd1,  // request outstanding at pc_q
    KILL = 2'd2,  // request outstanding whose answer will be discarded
    FULL = 2'd3   // skid buffer occupied, fetching paused
  } fetch_state_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] ins;
    logic [31:0] pc_plus_4;
  } if_id_t;

  // Plain 32-bit addition: the carry out of bit 31 is discarded, so the
  // address space wraps from 0xFFFF_FFFC to 0x0000_0000.
  function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// -----------------------------------------------------------------------------
// fetch_skid_buf
// One-entry holding buffer for an instruction that returned from memory while
// ID was stalled. The memory cannot be asked to hold its response, so the word
// is parked here until IF/ID can take it.
//   clk, rst_n         : clock, asynchronous active-low reset
//   load               : capture load_ins / load_pc_plus_4
//   drain              : entry has been moved into IF/ID; empty the buffer
//   clear              : discard the entry (redirect)
//   load_ins           : instruction word to capture
//   load_pc_plus_4     : fetch address + 4 of that word
//   valid              : buffer holds an entry
//   ins, pc_plus_4     : buffered entry
// -----------------------------------------------------------------------------
module fetch_skid_buf
  import pipeline_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        drain,
  input  logic        clear,
  input  logic [31:0] load_ins,
  input  logic [31:0] load_pc_plus_4,
  output logic        valid,
  output logic [31:0] ins,
  output logic [31:0] pc_plus_4
);

  // NOTE: the data fields are reset as well as the valid bit. It costs little
  // for a single entry and keeps X out of every downstream mux in simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid     <= 1'b0;
      ins       <= NOP_INSTR;
      pc_plus_4 <= '0;
    end else if (clear || drain) begin
      // Emptying wins over loading; the sequencer never asks for both.
      valid <= 1'b0;
    end else if (load) begin
      valid     <= 1'b1;
      ins       <= load_ins;
      pc_plus_4 <= load_pc_plus_4;
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// -----------------------------------------------------------------------------
// fetch_pc_unit
// Instruction-fetch front end: owns the program counter, runs a
// single-outstanding-request handshake with instruction memory and fills the
// IF/ID register. A redirect from ID squashes every younger fetch (no delay
// slot).
//   clk, rst_n          : clock, asynchronous active-low reset
//   stall_i             : ID cannot accept; IF/ID holds
//   redirect_i          : ID resolved a taken control transfer
//   redirect_addr_i     : its target
//   imem_req_o          : fetch request
//   imem_addr_o         : fetch address (stable while waiting)
//   imem_ready_i        : response valid this cycle (zero wait allowed)
//   imem_rdata_i        : fetched instruction
//   if_id_valid_o       : IF/ID holds a live instruction
//   if_id_ins_o         : IF/ID instruction (NOP_INSTR when invalid)
//   if_id_pc_plus_4_o   : IF/ID fetch address + 4
//   pc_o                : current fetch address
// -----------------------------------------------------------------------------
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC  = pipeline_pkg::RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = pipeline_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_addr_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic [31:0] imem_rdata_i,
  output logic        if_id_valid_o,
  output logic [31:0] if_id_ins_o,
  output logic [31:0] if_id_pc_plus_4_o,
  output logic [31:0] pc_o
);

  import pipeline_pkg::*;

  fetch_state_e state;
  logic [31:0]  pc_q;
  logic [31:0]  redir_q;   // target remembered while the stale request drains
  logic         req_q;
  if_id_t       if_id_q;

  logic [31:0]  pc_seq;
  logic         redir_ok;
  logic         fetch_hit;

  logic         skid_load;
  logic         skid_drain;
  logic         skid_valid;
  logic [31:0]  skid_ins;
  logic [31:0]  skid_pc_plus_4;

  assign pc_seq = next_seq_pc(pc_q);

  // A redirect is only meaningful for a live instruction that ID is actually
  // consuming this cycle; anything else on redirect_i is ignored.
  assign redir_ok = redirect_i && !stall_i && if_id_q.valid;

  // A response landing in REQ belongs to pc_q. In KILL it belongs to a
  // squashed path and never counts as a hit.
  assign fetch_hit = (state == REQ) && imem_ready_i;

  // Response arrived but ID is stalled: park it. redir_ok cannot be set here
  // because it requires stall_i=0.
  assign skid_load  = fetch_hit && stall_i;
  assign skid_drain = (state == FULL) && !stall_i && !redir_ok;

  fetch_skid_buf u_skid (
    .clk            (clk),
    .rst_n          (rst_n),
    .load           (skid_load),
    .drain          (skid_drain),
    .clear          (redir_ok),
    .load_ins       (imem_rdata_i),
    .load_pc_plus_4 (pc_seq),
    .valid          (skid_valid),
    .ins            (skid_ins),
    .pc_plus_4      (skid_pc_plus_4)
  );

  // NOTE: every register in this block uses non-blocking assignment so all
  // right-hand sides read the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= BOOT;
      pc_q    <= RESET_PC;
      redir_q <= '0;
      req_q   <= 1'b0;
      if_id_q <= '{valid: 1'b0, ins: NOP_INSTR, pc_plus_4: 32'd0};
    end else begin
      // ---------------- IF/ID register ----------------
      if (redir_ok) begin
        // The redirecting instruction leaves; whatever follows it is younger
        // and wrong-path, so IF/ID goes empty.
        if_id_q.valid <= 1'b0;
        if_id_q.ins   <= NOP_INSTR;
      end else if (!stall_i) begin
        if (fetch_hit) begin
          if_id_q <= '{valid: 1'b1, ins: imem_rdata_i, pc_plus_4: pc_seq};
        end else if ((state == FULL) && skid_valid) begin
          if_id_q <= '{valid: 1'b1, ins: skid_ins, pc_plus_4: skid_pc_plus_4};
        end else begin
          // ID took the old entry and nothing new arrived: bubble.
          if_id_q.valid <= 1'b0;
          if_id_q.ins   <= NOP_INSTR;
        end
      end

      // ---------------- fetch sequencer ----------------
      // req_q is updated alongside the state so imem_req_o comes straight
      // from a flop and is 1 exactly in REQ and KILL.
      case (state)
        BOOT: begin
          state <= REQ;
          req_q <= 1'b1;
        end

        REQ: begin
          if (imem_ready_i) begin
            if (redir_ok) begin
              // Same-cycle redirect: the returning word is wrong-path.
              pc_q <= redirect_addr_i;
            end else begin
              pc_q <= pc_seq;
              if (stall_i) begin
                state <= FULL;
                req_q <= 1'b0;
              end
            end
          end else if (redir_ok) begin
            // Cannot retract an issued request; wait for it and discard it.
            redir_q <= redirect_addr_i;
            state   <= KILL;
          end
        end

        KILL: begin
          if (imem_ready_i) begin
            pc_q  <= redir_q;
            state <= REQ;
          end
        end

        FULL: begin
          if (redir_ok) begin
            pc_q  <= redirect_addr_i;
            state <= REQ;
            req_q <= 1'b1;
          end else if (!stall_i) begin
            // Buffered word moves into IF/ID this edge; pc_q already points
            // past it, so fetch resumes without loss or duplication.
            state <= REQ;
            req_q <= 1'b1;
          end
        end

        default: begin
          state <= BOOT;
          req_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req_o        = req_q;
  assign imem_addr_o       = pc_q;
  assign pc_o              = pc_q;
  assign if_id_valid_o     = if_id_q.valid;
  assign if_id_ins_o       = if_id_q.ins;
  assign if_id_pc_plus_4_o = if_id_q.pc_plus_4;

endmodule
